// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the byte-wide memory port arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;

  localparam logic READ_SIT  = 1'b1;
  localparam logic WRITE_SIT = 1'b0;

  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LSU   = 1'b1
  } owner_e;

  // Access length in bytes; the reserved width code behaves as a word.
  function automatic logic [CNT_W-1:0] width_to_len(input logic [1:0] width);
    case (width)
      WIDTH_B: width_to_len = CNT_W'(1);
      WIDTH_H: width_to_len = CNT_W'(2);
      default: width_to_len = CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_serializer.sv
// Turns one latched request into per-byte RAM cycles: address stepping,
// write byte extraction, read byte assembly and IO-region store stalls.
module mem_byte_serializer
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              start_i,
  input  logic              run_i,
  input  logic              clear_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic              io_full_i,
  input  logic [BYTE_W-1:0] mem_din_i,
  output logic              done_c_o,
  output logic [DATA_W-1:0] rdata_c_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [BYTE_W-1:0] mem_dout_o,
  output logic              mem_wr_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  k_q;
  logic [CNT_W-1:0]  cap_q;
  logic              rw_q;
  logic              rd_iss_q;
  logic              din_vld_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [BYTE_W-1:0] mem_dout_q;
  logic              mem_wr_q;

  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_wdata;
  logic [CNT_W-1:0]  src_len;
  logic [CNT_W-1:0]  src_k;
  logic              src_rw;
  logic [ADDR_W-1:0] iss_addr;
  logic [BYTE_W-1:0] iss_byte;
  logic              stall;
  logic              issue;
  logic              capture;
  logic [CNT_W-1:0]  k_d;

  // Pick the request source (new grant or latched), decide this cycle's byte.
  always_comb begin
    src_addr  = start_i ? addr_i  : addr_q;
    src_wdata = start_i ? wdata_i : wdata_q;
    src_len   = start_i ? len_i   : len_q;
    src_rw    = start_i ? rw_i    : rw_q;
    src_k     = start_i ? '0      : k_q;
    iss_addr  = src_addr + ADDR_W'(src_k);
    iss_byte  = BYTE_W'(src_wdata >> {src_k, 3'b000});
    stall     = (src_rw == WRITE_SIT) && (iss_addr[17:16] == IO_SEL) && io_full_i;
    issue     = (start_i || run_i) && !clear_i && (src_k < src_len) && !stall;
    k_d       = clear_i ? '0 : (issue ? src_k + CNT_W'(1) : src_k);
    capture   = run_i && !clear_i && rw_q && din_vld_q;
    rdata_c_o = acc_q;
    if (capture) begin
      rdata_c_o[{cap_q[1:0], 3'b000} +: BYTE_W] = mem_din_i;
    end
    done_c_o  = run_i && !clear_i &&
                (rw_q ? (capture && (cap_q == len_q - CNT_W'(1))) : (k_q == len_q));
  end

  // Latch request fields, step the counters and register the RAM pins.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      acc_q      <= '0;
      len_q      <= '0;
      k_q        <= '0;
      cap_q      <= '0;
      rw_q       <= READ_SIT;
      rd_iss_q   <= 1'b0;
      din_vld_q  <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
    end else if (rdy_in) begin
      if (start_i) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        len_q   <= len_i;
        rw_q    <= rw_i;
        acc_q   <= '0;
        cap_q   <= '0;
      end else if (clear_i) begin
        cap_q   <= '0;
      end else if (capture) begin
        acc_q   <= rdata_c_o;
        cap_q   <= cap_q + CNT_W'(1);
      end
      k_q        <= k_d;
      rd_iss_q   <= issue && (src_rw == READ_SIT);
      din_vld_q  <= rd_iss_q && !clear_i;
      mem_a_q    <= issue ? iss_addr : '0;
      mem_dout_q <= (issue && (src_rw == WRITE_SIT)) ? iss_byte : '0;
      mem_wr_q   <= issue && (src_rw == WRITE_SIT);
    end
  end

  assign mem_a_o    = mem_a_q;
  assign mem_dout_o = mem_dout_q;
  assign mem_wr_o   = mem_wr_q && rdy_in;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between instruction fetch and the LSU.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter logic [1:0]  IO_SEL     = IO_SEL_DEFAULT
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_enable,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_end,
  output logic [DATA_WIDTH-1:0] if_data,
  input  logic                  lsu_enable,
  input  logic                  lsu_rw,
  input  logic [1:0]            lsu_width,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_end,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_available,
  input  logic                  rollback_flag_from_rob,
  input  logic                  io_buffer_full,
  output logic [ADDR_WIDTH-1:0] mem_a,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr
);

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_grant_q;
  logic              if_end_q;
  logic [DATA_W-1:0] if_data_q;
  logic              lsu_end_q;
  logic [DATA_W-1:0] lsu_rdata_q;
  logic              lsu_available_q;

  logic              fetch_req;
  logic              grant_any;
  logic              grant_lsu;
  logic              start_c;
  logic              run_c;
  logic              abort_c;
  logic              src_rw;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_wdata;
  logic [CNT_W-1:0]  src_len;
  logic              done_c;
  logic [DATA_W-1:0] rdata_c;

  // Round-robin grant in IDLE; a flushing ROB blocks new fetches.
  always_comb begin
    fetch_req = if_enable && !rollback_flag_from_rob;
    grant_any = fetch_req || lsu_enable;
    grant_lsu = (fetch_req && lsu_enable) ? (last_grant_q == OWN_FETCH) : lsu_enable;
    start_c   = (state_q == ST_IDLE) && grant_any;
    run_c     = (state_q != ST_IDLE);
    abort_c   = run_c && (owner_q == OWN_FETCH) && rollback_flag_from_rob;
    src_rw    = grant_lsu ? lsu_rw : READ_SIT;
    src_addr  = grant_lsu ? ADDR_W'(lsu_addr) : ADDR_W'(if_addr);
    src_wdata = DATA_W'(lsu_wdata);
    src_len   = grant_lsu ? width_to_len(lsu_width) : CNT_W'(4);
  end

  mem_byte_serializer #(
    .IO_SEL(IO_SEL)
  ) u_ser (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .start_i   (start_c),
    .run_i     (run_c),
    .clear_i   (abort_c),
    .rw_i      (src_rw),
    .addr_i    (src_addr),
    .wdata_i   (src_wdata),
    .len_i     (src_len),
    .io_full_i (io_buffer_full),
    .mem_din_i (mem_din),
    .done_c_o  (done_c),
    .rdata_c_o (rdata_c),
    .mem_a_o   (mem_a),
    .mem_dout_o(mem_dout),
    .mem_wr_o  (mem_wr)
  );

  // Access FSM: owner tracking, fetch abort on rollback, completion handshakes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= ST_IDLE;
      owner_q         <= OWN_FETCH;
      last_grant_q    <= OWN_FETCH;
      if_end_q        <= 1'b0;
      if_data_q       <= '0;
      lsu_end_q       <= 1'b0;
      lsu_rdata_q     <= '0;
      lsu_available_q <= 1'b0;
    end else if (rdy_in) begin
      if_end_q  <= 1'b0;
      lsu_end_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          lsu_available_q <= !grant_any;
          if (grant_any) begin
            owner_q      <= grant_lsu ? OWN_LSU : OWN_FETCH;
            last_grant_q <= grant_lsu ? OWN_LSU : OWN_FETCH;
            state_q      <= (src_rw == READ_SIT) ? ST_READ : ST_WRITE;
          end
        end
        ST_READ, ST_WRITE: begin
          if (abort_c) begin
            state_q         <= ST_IDLE;
            lsu_available_q <= 1'b1;
          end else if (done_c) begin
            state_q         <= ST_IDLE;
            lsu_available_q <= 1'b1;
            if (owner_q == OWN_FETCH) begin
              if_end_q  <= 1'b1;
              if_data_q <= rdata_c;
            end else begin
              lsu_end_q <= 1'b1;
              if (state_q == ST_READ) begin
                lsu_rdata_q <= rdata_c;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_end        = if_end_q;
  assign if_data       = DATA_WIDTH'(if_data_q);
  assign lsu_end       = lsu_end_q;
  assign lsu_rdata     = DATA_WIDTH'(lsu_rdata_q);
  assign lsu_available = lsu_available_q;

endmodule
